change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  in  1  synchronous active-low reset.
REQ-004 done_in  in  1  transaction-complete level from upstream vending controller; only its rising edge is used.
REQ-005 change_in  in  4  change owed in units, unsigned 0..15; sampled on done_in rising edge.
REQ-006 coin_ack  in  1  coin mechanism accepted the presented coin.
REQ-007 refill_en  in  1  add refill_qty to stock selected by refill_sel.
REQ-008 refill_sel  in  2  01=1-unit, 10=2-unit, 11=5-unit, 00=no-op.
REQ-009 refill_qty  in  4  coins to add.
REQ-010 clr_fault  in  1  leave FAULT.
REQ-011 coin_valid  out  1  coin presented to mechanism.
REQ-012 coin_type  out  2  01=1, 10=2, 11=5, 00 when coin_valid low.
REQ-013 remaining  out  4  change still owed.
REQ-014 busy  out  1  high in SELECT, ISSUE, DONE.
REQ-015 change_done  out  1  one-cycle pulse, change fully paid.
REQ-016 fault  out  1  high in FAULT.
REQ-017 stock1, stock2, stock5  out  4 each  coin counts per denomination.
REQ-018 state  out  3  FSM state: IDLE=0, SELECT=1, ISSUE=2, DONE=3, FAULT=4.

Function
REQ-019 done_in SHALL be registered (done_q, reset 0); start = done_in & ~done_q, evaluated only in IDLE.
REQ-020 IDLE: on start with change_in!=0, load remaining=change_in, go SELECT; on start with change_in==0, go DONE; else stay.
REQ-021 SELECT (one cycle): choose largest d in {5,2,1} with d<=remaining and stock_d>0; latch coin_type, go ISSUE; if none qualifies, go FAULT.
REQ-022 ISSUE: coin_valid=1; coin_type SHALL hold stable until coin_ack sampled high.
REQ-023 On coin_ack in ISSUE: remaining-=d, stock_d-=1 same edge; go DONE if new remaining==0, else SELECT.
REQ-024 coin_ack outside ISSUE SHALL be ignored.
REQ-025 Latency: start sampled on edge N -> SELECT after N, coin_valid high after edge N+1.
REQ-026 DONE: change_done=1 for exactly one cycle, then IDLE.
REQ-027 FAULT: fault=1, remaining and stocks held; clr_fault -> IDLE with remaining cleared to 0.
REQ-028 Refill SHALL be accepted only in IDLE or FAULT; ignored in other states.
REQ-029 Refill SHALL saturate at 15 (stock+qty>15 -> 15).
REQ-030 Refill and start in the same IDLE cycle: both take effect; SELECT sees updated stock.
REQ-031 done_in falling or re-rising outside IDLE SHALL be ignored; no queuing.
REQ-032 Subtraction SHALL never underflow (guaranteed by REQ-021 selection rule).

Reset
REQ-033 rst_n low at an edge SHALL force: state=IDLE, done_q=0, remaining=0, coin_valid=0, coin_type=00, change_done=0, fault=0, busy=0, stock1=stock2=stock5=0.
REQ-034 Reset SHALL take priority over every other input, including mid-ISSUE with coin_ack high.

Verification
REQ-035 Stocks 1:2, 2:2, 5:2; done_in rises with change_in=8; ack each coin next cycle -> coins 11,10,01 in order, change_done pulse, stocks 1/1/1, remaining 0.
REQ-036 Stocks 5:0, 2:3, 1:0; change_in=7 -> coins 10,10,10, then FAULT with remaining=1, stock2=0; clr_fault -> IDLE, remaining=0.
REQ-037 change_in=0 at done_in rise -> DONE next cycle, single change_done pulse, coin_valid never high.
REQ-038 coin_ack held low 5 cycles in ISSUE with refill_en=1 -> coin_valid/coin_type stable, stocks unchanged.
REQ-039 stock1=12, refill_sel=01, refill_qty=6 in IDLE -> stock1=15.
REQ-040 rst_n low during ISSUE with coin_ack=1 -> next edge all outputs per REQ-033, stocks 0.

Source files
------------

// File: rtl/change_dispenser.sv
// Change dispenser: pays out owed change greedily from 5/2/1-unit coin stocks,
// presenting one coin at a time to the coin mechanism and waiting for its ack.
module change_dispenser (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       done_in,
  input  logic [3:0] change_in,
  input  logic       coin_ack,
  input  logic       refill_en,
  input  logic [1:0] refill_sel,
  input  logic [3:0] refill_qty,
  input  logic       clr_fault,
  output logic       coin_valid,
  output logic [1:0] coin_type,
  output logic [3:0] remaining,
  output logic       busy,
  output logic       change_done,
  output logic       fault,
  output logic [3:0] stock1,
  output logic [3:0] stock2,
  output logic [3:0] stock5,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;
  localparam logic [1:0] COIN_5    = 2'b11;

  state_t     state_r, state_nxt_s;
  logic       done_q_r;
  logic [3:0] rem_r, rem_nxt_s;
  logic [3:0] stock1_r, stock1_nxt_s;
  logic [3:0] stock2_r, stock2_nxt_s;
  logic [3:0] stock5_r, stock5_nxt_s;
  logic [1:0] coin_type_r, coin_type_nxt_s;
  logic       coin_valid_r, busy_r, change_done_r, fault_r;
  logic       start_s;
  logic [1:0] sel_type_s;
  logic [3:0] rem_after_ack_s;

  // Saturating 4-bit add used by refill.
  function automatic logic [3:0] sat_add(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > 5'd15) ? 4'd15 : sum[3:0];
  endfunction

  // Unit value of an encoded coin type.
  function automatic logic [3:0] coin_value(input logic [1:0] ct);
    logic [3:0] v;
    case (ct)
      COIN_1:  v = 4'd1;
      COIN_2:  v = 4'd2;
      COIN_5:  v = 4'd5;
      default: v = 4'd0;
    endcase
    return v;
  endfunction

  assign start_s         = done_in & ~done_q_r;
  assign rem_after_ack_s = rem_r - coin_value(coin_type_r);

  // Greedy selection: largest denomination that fits and is in stock.
  always_comb begin
    sel_type_s = COIN_NONE;
    if (rem_r >= 4'd5 && stock5_r != 4'd0) begin
      sel_type_s = COIN_5;
    end else if (rem_r >= 4'd2 && stock2_r != 4'd0) begin
      sel_type_s = COIN_2;
    end else if (rem_r >= 4'd1 && stock1_r != 4'd0) begin
      sel_type_s = COIN_1;
    end else begin
      sel_type_s = COIN_NONE;
    end
  end

  // Next-state, datapath and stock update logic.
  always_comb begin
    state_nxt_s     = state_r;
    rem_nxt_s       = rem_r;
    stock1_nxt_s    = stock1_r;
    stock2_nxt_s    = stock2_r;
    stock5_nxt_s    = stock5_r;
    coin_type_nxt_s = coin_type_r;

    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          if (change_in != 4'd0) begin
            rem_nxt_s   = change_in;
            state_nxt_s = ST_SELECT;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SELECT: begin
        if (sel_type_s != COIN_NONE) begin
          coin_type_nxt_s = sel_type_s;
          state_nxt_s     = ST_ISSUE;
        end else begin
          state_nxt_s = ST_FAULT;
        end
      end
      ST_ISSUE: begin
        if (coin_ack) begin
          rem_nxt_s       = rem_after_ack_s;
          coin_type_nxt_s = COIN_NONE;
          case (coin_type_r)
            COIN_1:  stock1_nxt_s = stock1_r - 4'd1;
            COIN_2:  stock2_nxt_s = stock2_r - 4'd1;
            COIN_5:  stock5_nxt_s = stock5_r - 4'd1;
            default: stock1_nxt_s = stock1_r;
          endcase
          state_nxt_s = (rem_after_ack_s == 4'd0) ? ST_DONE : ST_SELECT;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      ST_FAULT: begin
        if (clr_fault) begin
          rem_nxt_s   = 4'd0;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_FAULT;
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        rem_nxt_s       = 4'd0;
        coin_type_nxt_s = COIN_NONE;
      end
    endcase

    // Refill is only honoured while no payout is in progress.
    if (refill_en && (state_r == ST_IDLE || state_r == ST_FAULT)) begin
      case (refill_sel)
        COIN_1:  stock1_nxt_s = sat_add(stock1_r, refill_qty);
        COIN_2:  stock2_nxt_s = sat_add(stock2_r, refill_qty);
        COIN_5:  stock5_nxt_s = sat_add(stock5_r, refill_qty);
        default: stock1_nxt_s = stock1_r;
      endcase
    end else begin
      stock5_nxt_s = stock5_nxt_s;
    end
  end

  // State, datapath and registered output flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      done_q_r      <= 1'b0;
      rem_r         <= 4'd0;
      stock1_r      <= 4'd0;
      stock2_r      <= 4'd0;
      stock5_r      <= 4'd0;
      coin_type_r   <= COIN_NONE;
      coin_valid_r  <= 1'b0;
      busy_r        <= 1'b0;
      change_done_r <= 1'b0;
      fault_r       <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      done_q_r      <= done_in;
      rem_r         <= rem_nxt_s;
      stock1_r      <= stock1_nxt_s;
      stock2_r      <= stock2_nxt_s;
      stock5_r      <= stock5_nxt_s;
      coin_type_r   <= coin_type_nxt_s;
      coin_valid_r  <= (state_nxt_s == ST_ISSUE);
      busy_r        <= (state_nxt_s == ST_SELECT) || (state_nxt_s == ST_ISSUE) ||
                       (state_nxt_s == ST_DONE);
      change_done_r <= (state_nxt_s == ST_DONE);
      fault_r       <= (state_nxt_s == ST_FAULT);
    end
  end

  assign state       = state_r;
  assign remaining   = rem_r;
  assign stock1      = stock1_r;
  assign stock2      = stock2_r;
  assign stock5      = stock5_r;
  assign coin_type   = coin_type_r;
  assign coin_valid  = coin_valid_r;
  assign busy        = busy_r;
  assign change_done = change_done_r;
  assign fault       = fault_r;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser with hand-computed expectations.
module tb_change_dispenser;

  logic       clk;
  logic       rst_n;
  logic       done_in;
  logic [3:0] change_in;
  logic       coin_ack;
  logic       refill_en;
  logic [1:0] refill_sel;
  logic [3:0] refill_qty;
  logic       clr_fault;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic [3:0] remaining;
  logic       busy;
  logic       change_done;
  logic       fault;
  logic [3:0] stock1, stock2, stock5;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  change_dispenser dut (
    .clk(clk), .rst_n(rst_n), .done_in(done_in), .change_in(change_in),
    .coin_ack(coin_ack), .refill_en(refill_en), .refill_sel(refill_sel),
    .refill_qty(refill_qty), .clr_fault(clr_fault), .coin_valid(coin_valid),
    .coin_type(coin_type), .remaining(remaining), .busy(busy),
    .change_done(change_done), .fault(fault), .stock1(stock1),
    .stock2(stock2), .stock5(stock5), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one active edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_refill(input logic [1:0] sel, input logic [3:0] qty);
    refill_en  = 1'b1;
    refill_sel = sel;
    refill_qty = qty;
    tick();
    refill_en  = 1'b0;
    refill_sel = 2'b00;
    refill_qty = 4'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_state"},  state,       8'd0);
    check_eq({tag, "_rem"},    remaining,   8'd0);
    check_eq({tag, "_cv"},     coin_valid,  8'd0);
    check_eq({tag, "_ct"},     coin_type,   8'd0);
    check_eq({tag, "_busy"},   busy,        8'd0);
    check_eq({tag, "_cd"},     change_done, 8'd0);
    check_eq({tag, "_fault"},  fault,       8'd0);
    check_eq({tag, "_s1"},     stock1,      8'd0);
    check_eq({tag, "_s2"},     stock2,      8'd0);
    check_eq({tag, "_s5"},     stock5,      8'd0);
  endtask

  logic [1:0] exp_type [3];
  logic [3:0] exp_rem  [3];

  initial begin
    rst_n = 1'b0; done_in = 1'b0; change_in = 4'd0; coin_ack = 1'b0;
    refill_en = 1'b0; refill_sel = 2'b00; refill_qty = 4'd0; clr_fault = 1'b0;
    tick();
    tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Greedy payout of 8 from 2/2/2 stock: 5, 2, 1.
    do_refill(2'b01, 4'd2);
    do_refill(2'b10, 4'd2);
    do_refill(2'b11, 4'd2);
    check_eq("fill_s1", stock1, 8'd2);
    check_eq("fill_s5", stock5, 8'd2);
    change_in = 4'd8;
    done_in   = 1'b1;
    tick();
    done_in = 1'b0;
    check_eq("p8_sel_state", state, 8'd1);
    check_eq("p8_sel_rem",   remaining, 8'd8);
    check_eq("p8_sel_busy",  busy, 8'd1);
    check_eq("p8_sel_cv",    coin_valid, 8'd0);
    tick();
    check_eq("p8_iss_cv", coin_valid, 8'd1);
    // Stall in ISSUE with a refill attempt that must be ignored.
    refill_en = 1'b1; refill_sel = 2'b11; refill_qty = 4'd5;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("stall_cv", coin_valid, 8'd1);
      check_eq("stall_ct", coin_type, 8'd3);
      check_eq("stall_s5", stock5, 8'd2);
      check_eq("stall_state", state, 8'd2);
    end
    refill_en = 1'b0; refill_sel = 2'b00; refill_qty = 4'd0;

    exp_type[0] = 2'b11; exp_type[1] = 2'b10; exp_type[2] = 2'b01;
    exp_rem[0]  = 4'd3;  exp_rem[1]  = 4'd1;  exp_rem[2]  = 4'd0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        tick();
        check_eq("p8_iss_cv", coin_valid, 8'd1);
      end
      check_eq("p8_coin", coin_type, {6'd0, exp_type[i]});
      coin_ack = 1'b1;
      tick();
      coin_ack = 1'b0;
      check_eq("p8_rem", remaining, {4'd0, exp_rem[i]});
      check_eq("p8_ack_cv", coin_valid, 8'd0);
    end
    check_eq("p8_done_state", state, 8'd3);
    check_eq("p8_done_pulse", change_done, 8'd1);
    check_eq("p8_s1", stock1, 8'd1);
    check_eq("p8_s2", stock2, 8'd1);
    check_eq("p8_s5", stock5, 8'd1);
    tick();
    check_eq("p8_idle", state, 8'd0);
    check_eq("p8_pulse_end", change_done, 8'd0);
    check_eq("p8_busy_end", busy, 8'd0);

    // Only 2-unit coins for 7 owed: three coins then FAULT with 1 left.
    do_reset();
    do_refill(2'b10, 4'd3);
    change_in = 4'd7;
    done_in   = 1'b1;
    tick();
    done_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("p7_coin", coin_type, 8'd2);
      coin_ack = 1'b1;
      tick();
      coin_ack = 1'b0;
    end
    check_eq("p7_rem1", remaining, 8'd1);
    tick();
    check_eq("p7_fault_state", state, 8'd4);
    check_eq("p7_fault", fault, 8'd1);
    check_eq("p7_busy", busy, 8'd0);
    check_eq("p7_s2", stock2, 8'd0);
    coin_ack = 1'b1;
    tick();
    coin_ack = 1'b0;
    check_eq("p7_ack_ign_rem", remaining, 8'd1);
    check_eq("p7_ack_ign_st", state, 8'd4);
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    check_eq("p7_clr_state", state, 8'd0);
    check_eq("p7_clr_rem", remaining, 8'd0);
    check_eq("p7_clr_fault", fault, 8'd0);

    // Zero change owed: straight to DONE, no coin.
    change_in = 4'd0;
    done_in   = 1'b1;
    tick();
    check_eq("z_state", state, 8'd3);
    check_eq("z_pulse", change_done, 8'd1);
    check_eq("z_cv", coin_valid, 8'd0);
    tick();
    check_eq("z_idle", state, 8'd0);
    check_eq("z_pulse_end", change_done, 8'd0);
    tick();
    check_eq("z_level_no_retrig", state, 8'd0);
    check_eq("z_cv_end", coin_valid, 8'd0);
    done_in = 1'b0;

    // Refill saturation and no-op selector.
    do_reset();
    do_refill(2'b01, 4'd12);
    check_eq("sat_s1_12", stock1, 8'd12);
    do_refill(2'b01, 4'd6);
    check_eq("sat_s1_15", stock1, 8'd15);
    do_refill(2'b00, 4'd4);
    check_eq("noop_s1", stock1, 8'd15);
    check_eq("noop_s2", stock2, 8'd0);

    // Refill and start together: SELECT must see the new 5-unit coin.
    refill_en = 1'b1; refill_sel = 2'b11; refill_qty = 4'd1;
    change_in = 4'd5;
    done_in   = 1'b1;
    tick();
    refill_en = 1'b0; refill_sel = 2'b00; refill_qty = 4'd0;
    done_in   = 1'b0;
    check_eq("rs_s5", stock5, 8'd1);
    check_eq("rs_state", state, 8'd1);
    tick();
    check_eq("rs_coin", coin_type, 8'd3);

    // Reset wins over an ack during ISSUE.
    coin_ack = 1'b1;
    rst_n    = 1'b0;
    tick();
    coin_ack = 1'b0;
    rst_n    = 1'b1;
    check_reset_outputs("rst_iss");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
